cal_eep_spi_resp: RTL and testbench

//  SPI responder (slave) for the calibration EEPROM, the far end of the command processor's ss[2] SPI link.

---
 rtl/osc_spi_pkg.sv | 10 +
 rtl/spi_sync_edge.sv | 32 +++
 rtl/cal_eep_spi_resp.sv | 134 +++++++++++++
 tb/tb_cal_eep_spi_resp.sv | 134 +++++++++++++
 4 files changed

// File: rtl/osc_spi_pkg.sv
// osc_spi_pkg: opcodes, frame length and responder state encoding shared with the command processor
package osc_spi_pkg;

    localparam logic [1:0] EEP_OP_RD     = 2'b00;
    localparam logic [1:0] EEP_OP_WR     = 2'b01;
    localparam int         EEP_FRAME_LEN = 16;

    typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: 2-flop synchronizer for an async pin plus rise/fall detect on the synced level
module spi_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic s1, s2, s3;

    // two sync stages plus one delayed copy for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= RST_VAL;
            s2 <= RST_VAL;
            s3 <= RST_VAL;
        end else begin
            s1 <= d;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign q    = s2;
    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;

endmodule

// File: rtl/cal_eep_spi_resp.sv
// cal_eep_spi_resp: SPI mode-3 responder holding the 64x8 calibration store
module cal_eep_spi_resp
    import osc_spi_pkg::*;
#(
    parameter int                ADDR_W  = 6,
    parameter int                DATA_W  = 8,
    parameter logic [DATA_W-1:0] MEM_RST = '0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic SS_n,
    input  logic SCLK,
    input  logic MOSI,
    output logic MISO,
    output logic MISO_en,
    output logic wrt_done,
    output logic rd_done,
    output logic frm_err
);

    localparam int         DEPTH   = 2**ADDR_W;
    localparam int         CMD_W   = 2 + ADDR_W;
    localparam int         FRM_W   = CMD_W + DATA_W;
    localparam logic [4:0] CMD_LEN = 5'(CMD_W);
    localparam logic [4:0] FRM_LEN = 5'(FRM_W);

    logic              ss_s, ss_rise, ss_fall;
    logic              sclk_rise, sclk_fall, sclk_unused;
    logic              mosi_s, mosi_rise_unused, mosi_fall_unused;
    state_t            state, nxt_state;
    logic [4:0]        bit_cnt, nxt_cnt;
    logic [FRM_W-1:0]  rx, nxt_rx, sh_rx;
    logic [DATA_W-1:0] tx, nxt_tx;
    logic              wr_en, rd_p, err_p;
    logic [1:0]        cl_op;
    logic [ADDR_W-1:0] cl_addr;
    logic [DATA_W-1:0] mem [DEPTH];

    // SS_n and SCLK idle high, so their syncs reset high to avoid a false edge after reset
    spi_sync_edge #(.RST_VAL(1'b1)) u_ss (
        .clk(clk), .rst_n(rst_n), .d(SS_n), .q(ss_s), .rise(ss_rise), .fall(ss_fall)
    );
    spi_sync_edge #(.RST_VAL(1'b1)) u_sclk (
        .clk(clk), .rst_n(rst_n), .d(SCLK), .q(sclk_unused), .rise(sclk_rise), .fall(sclk_fall)
    );
    spi_sync_edge #(.RST_VAL(1'b0)) u_mosi (
        .clk(clk), .rst_n(rst_n), .d(MOSI), .q(mosi_s),
        .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    assign sh_rx   = {rx[FRM_W-2:0], mosi_s};
    assign cl_op   = rx[FRM_W-1 -: 2];
    assign cl_addr = rx[FRM_W-3 -: ADDR_W];
    assign MISO    = (state == DATA) & tx[DATA_W-1];
    assign MISO_en = ~ss_s;

    // next state, shifters and close-of-frame pulses; SS_n edges take priority over SCLK
    always_comb begin
        nxt_state = state;
        nxt_cnt   = bit_cnt;
        nxt_rx    = rx;
        nxt_tx    = tx;
        wr_en     = 1'b0;
        rd_p      = 1'b0;
        err_p     = 1'b0;
        if (ss_rise) begin
            if (state != IDLE) begin
                nxt_state = IDLE;
                wr_en     = (bit_cnt == FRM_LEN) && (cl_op == EEP_OP_WR);
                rd_p      = (bit_cnt == FRM_LEN) && (cl_op == EEP_OP_RD);
                err_p     = (bit_cnt != FRM_LEN);
            end
        end else if (ss_fall) begin
            nxt_state = CMD;
            nxt_cnt   = '0;
            nxt_rx    = '0;
        end else if (sclk_rise) begin
            case (state)
                CMD: begin
                    nxt_rx  = sh_rx;
                    nxt_cnt = bit_cnt + 5'd1;
                    if (bit_cnt == CMD_LEN - 5'd1) begin
                        nxt_state = DATA;
                        nxt_tx    = (sh_rx[CMD_W-1 -: 2] == EEP_OP_RD) ? mem[sh_rx[ADDR_W-1:0]] : '0;
                    end
                end
                DATA: begin
                    nxt_rx    = sh_rx;
                    nxt_cnt   = bit_cnt + 5'd1;
                    nxt_state = (bit_cnt == FRM_LEN - 5'd1) ? DONE : DATA;
                end
                DONE:    nxt_cnt = (bit_cnt == 5'd31) ? bit_cnt : bit_cnt + 5'd1;
                default: ;
            endcase
        end else if (sclk_fall && state == DATA && bit_cnt != CMD_LEN) begin
            nxt_tx = {tx[DATA_W-2:0], 1'b0};
        end
    end

    // frame state registers and single-cycle status pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            rx       <= '0;
            tx       <= '0;
            wrt_done <= 1'b0;
            rd_done  <= 1'b0;
            frm_err  <= 1'b0;
        end else begin
            state    <= nxt_state;
            bit_cnt  <= nxt_cnt;
            rx       <= nxt_rx;
            tx       <= nxt_tx;
            wrt_done <= wr_en;
            rd_done  <= rd_p;
            frm_err  <= err_p;
        end
    end

    // flop-based store so reset clears every location
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= MEM_RST;
        end else if (wr_en) begin
            mem[cal_addr_fix(cl_addr)] <= rx[DATA_W-1:0];
        end
    end

    function automatic logic [ADDR_W-1:0] cal_addr_fix(input logic [ADDR_W-1:0] a);
        return a;
    endfunction

endmodule

// File: tb/tb_cal_eep_spi_resp.sv
// tb_cal_eep_spi_resp: directed frame vectors plus a mid-frame reset sequence for the EEPROM responder
module tb_cal_eep_spi_resp;
    import osc_spi_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic SS_n = 1'b1;
    logic SCLK = 1'b1;
    logic MOSI = 1'b0;
    logic MISO, MISO_en, wrt_done, rd_done, frm_err;

    int n_chk = 0;
    int n_miss = 0;
    int n_wr = 0, n_rd = 0, n_fe = 0, n_bad = 0;
    logic pw = 1'b0, pr = 1'b0, pe = 1'b0;

    typedef struct {
        logic [15:0] frm;
        int          nbits;
        logic [7:0]  rd;
        int          pls;
    } vec_t;

    vec_t v[14];

    cal_eep_spi_resp dut (
        .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI),
        .MISO(MISO), .MISO_en(MISO_en), .wrt_done(wrt_done), .rd_done(rd_done), .frm_err(frm_err)
    );

    always #5 clk = ~clk;

    // pulse counters plus overlap and width checking
    always @(negedge clk) begin
        if (wrt_done) n_wr++;
        if (rd_done) n_rd++;
        if (frm_err) n_fe++;
        if (int'(wrt_done) + int'(rd_done) + int'(frm_err) > 1 ||
            (wrt_done && pw) || (rd_done && pr) || (frm_err && pe)) n_bad++;
        pw = wrt_done;
        pr = rd_done;
        pe = frm_err;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_bit(input logic b, inout logic [15:0] got, input int i);
        SCLK = 1'b0;
        MOSI = b;
        wait_clk(5);
        if (i < 16) got[15-i] = MISO;
        SCLK = 1'b1;
        wait_clk(5);
    endtask

    task automatic frame(input logic [15:0] frm, input int nbits, output logic [15:0] got);
        got = '0;
        SS_n = 1'b0;
        wait_clk(5);
        for (int i = 0; i < nbits; i++) spi_bit((i < 16) ? frm[15-i] : 1'b0, got, i);
        SS_n = 1'b1;
        wait_clk(4);
    endtask

    initial begin
        logic [15:0] g;
        int w0, r0, e0;
        v[0]  = '{16'h4A5C, 16, 8'h00, 100};
        v[1]  = '{16'h0A00, 16, 8'h5C, 10};
        v[2]  = '{16'h7FFF, 16, 8'h00, 100};
        v[3]  = '{16'h3F00, 16, 8'hFF, 10};
        v[4]  = '{16'h4A11, 12, 8'h00, 1};
        v[5]  = '{16'h0A00, 16, 8'h5C, 10};
        v[6]  = '{16'h4A77, 17, 8'h00, 1};
        v[7]  = '{16'h0A00, 16, 8'h5C, 10};
        v[8]  = '{16'h8A33, 16, 8'h00, 0};
        v[9]  = '{16'h0A00, 16, 8'h5C, 10};
        v[10] = '{16'hC0AA, 16, 8'h00, 0};
        v[11] = '{16'h0000, 16, 8'h00, 10};
        v[12] = '{16'h40A5, 16, 8'h00, 100};
        v[13] = '{16'h0000, 16, 8'hA5, 10};

        wait_clk(3);
        chk("reset_outputs", int'({MISO, MISO_en, wrt_done, rd_done, frm_err}), 0);
        rst_n = 1'b1;
        wait_clk(4);
        chk("idle_outputs", int'({MISO, MISO_en, wrt_done, rd_done, frm_err}), 0);

        for (int k = 0; k < 14; k++) begin
            w0 = n_wr; r0 = n_rd; e0 = n_fe;
            frame(v[k].frm, v[k].nbits, g);
            chk($sformatf("v%0d_data", k), int'(g[7:0]), int'(v[k].rd));
            chk($sformatf("v%0d_cmd_phase", k), int'(g[15:8]), 0);
            chk($sformatf("v%0d_pulses", k), (n_wr - w0) * 100 + (n_rd - r0) * 10 + (n_fe - e0), v[k].pls);
        end

        // read of 0x0A cut by reset after 10 bits; the partial data must be 0x5C's top bits
        frame(16'h4A5C, EEP_FRAME_LEN, g);
        w0 = n_wr; r0 = n_rd; e0 = n_fe;
        g = '0;
        SS_n = 1'b0;
        wait_clk(5);
        for (int i = 0; i < 10; i++) spi_bit(g[15] | ((16'h0A00 >> (15 - i)) & 16'h1) != 0, g, i);
        chk("partial_read_bits", int'(g[7:6]), 1);
        chk("miso_en_in_frame", int'(MISO_en), 1);
        rst_n = 1'b0;
        wait_clk(2);
        chk("reset_mid_frame_miso", int'({MISO, MISO_en}), 0);
        SS_n = 1'b1;
        wait_clk(4);
        rst_n = 1'b1;
        wait_clk(4);
        chk("reset_mid_frame_pulses", (n_wr - w0) + (n_rd - r0) + (n_fe - e0), 0);
        w0 = n_wr; r0 = n_rd; e0 = n_fe;
        frame(16'h0A00, EEP_FRAME_LEN, g);
        chk("post_reset_read", int'(g[7:0]), 0);
        chk("post_reset_pulses", (n_wr - w0) * 100 + (n_rd - r0) * 10 + (n_fe - e0), 10);

        chk("pulse_shape", n_bad, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_miss);
        $finish;
    end

endmodule
